// File: rtl/pspin_cfg_pkg.sv
// PsPIN configuration: cluster/core/command sizing and the command ID
// and response types shared by the command ID pool.
package pspin_cfg_pkg;

   localparam int unsigned NUM_CLUSTERS = 4;
   localparam int unsigned NUM_CORES    = 8;
   localparam int unsigned NUM_HPU_CMDS = 4;

   localparam int unsigned CLUSTER_W = $clog2(NUM_CLUSTERS);
   localparam int unsigned CORE_W    = $clog2(NUM_CORES);
   localparam int unsigned CMD_W     = $clog2(NUM_HPU_CMDS);

   typedef struct packed {
      logic [CLUSTER_W-1:0] cluster_id;
      logic [CORE_W-1:0]    core_id;
      logic [CMD_W-1:0]     local_cmd_id;
   } pspin_cmd_id_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
   } pspin_cmd_resp_t;

endpackage

// File: rtl/pspin_cmd_id_pool_if.sv
// Allocation and completion handshake bundle of the command ID pool.
// The master side requests IDs and returns completions.
interface pspin_cmd_id_pool_if
   import pspin_cfg_pkg::*;
#(
   parameter int unsigned NUM_CORES = 8
);

   logic [NUM_CORES-1:0]          alloc_req_i;
   logic [NUM_CORES-1:0]          alloc_gnt_o;
   pspin_cmd_id_t [NUM_CORES-1:0] alloc_id_o;
   logic                          resp_valid_i;
   pspin_cmd_resp_t               resp_i;

   modport master (
      output alloc_req_i,
      output resp_valid_i,
      output resp_i,
      input  alloc_gnt_o,
      input  alloc_id_o
   );

   modport slave (
      input  alloc_req_i,
      input  resp_valid_i,
      input  resp_i,
      output alloc_gnt_o,
      output alloc_id_o
   );

endinterface

// File: rtl/pspin_cmd_id_slot.sv
// One core's command ID slot: busy vector, optional rotating search
// pointer and first-free-index search.
module pspin_cmd_id_slot #(
   parameter int unsigned NUM_HPU_CMDS = 4,
   parameter int unsigned ROTATE_ALLOC = 0,
   localparam int unsigned IDW = $clog2(NUM_HPU_CMDS),
   localparam int unsigned CW  = $clog2(NUM_HPU_CMDS + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   output logic                    gnt_o,
   output logic [IDW-1:0]          sel_o,
   input  logic                    free_i,
   input  logic [IDW-1:0]          free_id_i,
   output logic [NUM_HPU_CMDS-1:0] busy_o,
   output logic [CW-1:0]           count_o
);

   logic [NUM_HPU_CMDS-1:0] busy_q;
   logic [NUM_HPU_CMDS-1:0] set_m;
   logic [NUM_HPU_CMDS-1:0] clr_m;
   logic [IDW-1:0]          start;
   logic [IDW-1:0]          idx;
   logic                    found;

   always_comb begin
      found = 1'b0;
      sel_o = '0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_HPU_CMDS; i++) begin
         idx = start + IDW'(i);
         if (!found && !busy_q[idx]) begin
            found = 1'b1;
            sel_o = idx;
         end
      end
   end

   assign gnt_o = req_i & found;

   always_comb begin
      set_m = '0;
      clr_m = '0;
      if (gnt_o) set_m[sel_o] = 1'b1;
      if (free_i) clr_m[free_id_i] = 1'b1;
   end

   // Allocation picks from the pre-free vector, so a freed bit is
   // only grantable from the following cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) busy_q <= '0;
      else         busy_q <= (busy_q | set_m) & ~clr_m;
   end

   if (ROTATE_ALLOC != 0) begin : g_rot
      logic [IDW-1:0] ptr_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)    ptr_q <= '0;
         else if (gnt_o) ptr_q <= sel_o + IDW'(1);
      end
      assign start = ptr_q;
   end else begin : g_fix
      assign start = '0;
   end

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < NUM_HPU_CMDS; i++)
         count_o = count_o + CW'(busy_q[i]);
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/pspin_cmd_id_pool.sv
// Per-core command ID pool: allocates local command IDs, retires them
// on completion responses and flags malformed responses.
module pspin_cmd_id_pool
   import pspin_cfg_pkg::*;
#(
   parameter int unsigned NUM_CORES    = 8,
   parameter int unsigned NUM_HPU_CMDS = 4,
   parameter int unsigned ROTATE_ALLOC = 0,
   localparam int unsigned IDW = $clog2(NUM_HPU_CMDS),
   localparam int unsigned CW  = $clog2(NUM_HPU_CMDS + 1)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [CLUSTER_W-1:0]           cluster_id_i,
   pspin_cmd_id_pool_if.slave             bus,
   input  logic [NUM_CORES-1:0][IDW-1:0]  wait_id_i,
   output logic [NUM_CORES-1:0]           wait_done_o,
   output logic [NUM_CORES-1:0][CW-1:0]   outstanding_o,
   output logic                           all_idle_o,
   output logic                           err_o
);

   logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] busy;
   logic [NUM_CORES-1:0][IDW-1:0]          sel;
   logic [NUM_CORES-1:0]                   gnt;
   logic [NUM_CORES-1:0]                   free;
   pspin_cmd_id_t [NUM_CORES-1:0]          ids;

   pspin_cmd_id_t  rid;
   logic [IDW-1:0] rlid;
   logic           cluster_ok;
   logic           core_ok;
   logic           busy_hit;
   logic           resp_ok;
   logic           err_q;

   assign rid        = bus.resp_i.cmd_id;
   assign rlid       = IDW'(rid.local_cmd_id);
   assign cluster_ok = rid.cluster_id == cluster_id_i;

   // Decode the target core without comparing against NUM_CORES so an
   // out-of-range core_id simply matches nothing.
   always_comb begin
      core_ok  = 1'b0;
      busy_hit = 1'b0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         if (rid.core_id == CORE_W'(c)) begin
            core_ok  = 1'b1;
            busy_hit = busy[c][rlid];
         end
      end
   end

   assign resp_ok = cluster_ok & core_ok & busy_hit;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      assign free[c] = bus.resp_valid_i & resp_ok &
                       (rid.core_id == CORE_W'(c));

      pspin_cmd_id_slot #(
         .NUM_HPU_CMDS (NUM_HPU_CMDS),
         .ROTATE_ALLOC (ROTATE_ALLOC)
      ) u_slot (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .req_i     (bus.alloc_req_i[c]),
         .gnt_o     (gnt[c]),
         .sel_o     (sel[c]),
         .free_i    (free[c]),
         .free_id_i (rlid),
         .busy_o    (busy[c]),
         .count_o   (outstanding_o[c])
      );

      assign ids[c].cluster_id   = cluster_id_i;
      assign ids[c].core_id      = CORE_W'(c);
      assign ids[c].local_cmd_id = CMD_W'(sel[c]);
      assign wait_done_o[c]      = ~busy[c][wait_id_i[c]];
   end

   assign bus.alloc_gnt_o = gnt;
   assign bus.alloc_id_o  = ids;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_q | (bus.resp_valid_i & ~resp_ok);
   end

   assign err_o      = err_q;
   assign all_idle_o = ~|busy;

endmodule

// File: doc/pspin_cmd_id_pool.md
PSPIN_CMD_ID_POOL -- requirements
Module: pspin_cmd_id_pool

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, the number of HPU cores served (>=1).
REQ-002 SHALL have parameter NUM_HPU_CMDS, default 4, the number of in-flight command IDs per core (power of 2, >=2).
REQ-003 SHALL have parameter ROTATE_ALLOC, default 0; 0 = lowest free ID, 1 = per-core rotating search start.
REQ-004 SHALL have one clock, clk_i, input, 1 bit; rising-edge clock.
REQ-005 SHALL have one asynchronous active-low reset, rst_ni, input, 1 bit.
REQ-006 cluster_id_i  input  $clog2(NUM_CLUSTERS)  static cluster index, stable after reset.
REQ-007 alloc_req_i  input  NUM_CORES  per-core ID allocation request.
REQ-008 alloc_gnt_o  output  NUM_CORES  per-core grant; the allocation completes when req and gnt are both high.
REQ-009 alloc_id_o  output  NUM_CORES x pspin_cmd_id_t  granted ID, valid when gnt is high.
REQ-010 resp_valid_i  input  1  completion response strobe.
REQ-011 resp_i  input  pspin_cmd_resp_t  completed command ID.
REQ-012 wait_id_i  input  NUM_CORES x $clog2(NUM_HPU_CMDS)  per-core queried local_cmd_id.
REQ-013 wait_done_o  output  NUM_CORES  queried ID not outstanding.
REQ-014 outstanding_o  output  NUM_CORES x $clog2(NUM_HPU_CMDS+1)  per-core in-flight count.
REQ-015 all_idle_o  output  1  no ID outstanding on any core.
REQ-016 err_o  output  1  sticky protocol error.

Function
REQ-017 Per core, SHALL keep a NUM_HPU_CMDS-bit busy vector and, if ROTATE_ALLOC=1, a search pointer.
REQ-018 alloc_gnt_o[c] SHALL be combinational: high iff alloc_req_i[c] is high and the busy vector has at least one free bit; grant does not depend on any other core.
REQ-019 alloc_id_o[c] SHALL carry cluster_id_i, core_id=c, and local_cmd_id = the first free index at or after the search start (start 0 when ROTATE_ALLOC=0, else the pointer), wrapping modulo NUM_HPU_CMDS.
REQ-020 On a granted allocation, the selected bit SHALL be set at the next edge; if ROTATE_ALLOC=1, the pointer SHALL become (selected+1) mod NUM_HPU_CMDS.
REQ-021 A valid response whose cluster_id matches, whose core_id < NUM_CORES, and whose ID is busy SHALL clear that bit at the next edge.
REQ-022 There SHALL be no same-cycle bypass: a freed ID becomes grantable one cycle after resp_valid_i.
REQ-023 A simultaneous allocation and free on the same core SHALL both take effect; the allocation selects from the pre-free vector.
REQ-024 A response with a cluster mismatch, core_id >= NUM_CORES, or a non-busy ID SHALL change no busy state and SHALL set err_o at the next edge.
REQ-025 err_o SHALL remain set until reset.
REQ-026 outstanding_o[c] SHALL equal the popcount of the registered busy vector.
REQ-027 all_idle_o SHALL be high iff every busy vector is zero.
REQ-028 wait_done_o[c] SHALL equal NOT busy[c][wait_id_i[c]] (combinational from registered state).
REQ-029 With a full vector, gnt SHALL be low, the request SHALL be held without loss, and the pool SHALL NOT retain the request.

Reset
REQ-030 On rst_ni low, asynchronously: all busy vectors SHALL clear, pointers SHALL be 0, and err_o SHALL be 0.
REQ-031 During reset: alloc_gnt_o follows alloc_req_i, outstanding_o=0, all_idle_o=1, wait_done_o=all ones.
REQ-032 Responses to IDs issued before a reset mid-operation SHALL be flagged as errors per REQ-024.

Structure
REQ-033 pspin_cmd_id_t, pspin_cmd_resp_t, NUM_CLUSTERS, NUM_CORES, and NUM_HPU_CMDS SHALL come from pspin_cfg_pkg; no new package types.
REQ-034 A single sub-module, pspin_cmd_id_slot, SHALL implement one core's busy vector, pointer, and free-index search, and SHALL be instantiated NUM_CORES times.

Verification
REQ-035 Core 0 requests 4 cycles continuously, ROTATE_ALLOC=0 -> IDs 0,1,2,3 granted; 5th cycle gnt=0; outstanding_o[0]=4.
REQ-036 Full core 2, then respond ID 1 -> gnt low in the response cycle; the next cycle grants ID 1; err_o stays 0.
REQ-037 ROTATE_ALLOC=1: allocate 0, free 0, allocate -> ID 1 granted (not 0).
REQ-038 Core 3 has IDs 0-3 busy; same cycle: request plus response for ID 2 -> gnt=0 that cycle; ID 2 granted the next cycle.
REQ-039 Response for cluster 1 while cluster_id_i=0, and for idle ID 3 -> err_o=1 sticky, all busy vectors unchanged.
REQ-040 All 8 cores hold 2 IDs, rst_ni pulsed mid-cycle -> outstanding all 0 and all_idle_o=1 immediately; a stale response after reset sets err_o.
